gate_exerciser: RTL and testbench
=================================

GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, wait cycles after each input vector is driven, before y_in is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  run request, sampled only in IDLE.
REQ-005 Port: gate_sel  input  3  expected gate type, latched at start: 0 NOR, 1 OR, 2 AND, 3 NAND, 4 XOR, 5 XNOR, 6-7 illegal.
REQ-006 Port: y_in  input  1  output of the 2-input gate under test.
REQ-007 Port: a_out  output  1  registered drive to gate input a.
REQ-008 Port: b_out  output  1  registered drive to gate input b.
REQ-009 Port: busy  output  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
REQ-010 Port: done  output  1  one-cycle pulse at end of run.
REQ-011 Port: pass  output  1  1 when the last run had zero mismatches and a legal gate_sel; held until the next accepted start.
REQ-012 Port: err_cnt  output  3  mismatch count of the last run, 0..4.
REQ-013 Port: fail_vec  output  4  bit i set when vector i mismatched; vector i is {a,b} = i[1:0].
REQ-014 Port: sel_err  output  1  high when the last run's latched gate_sel was 6 or 7.

Function
REQ-015 The FSM states SHALL be IDLE, SETTLE, SAMPLE, and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch gate_sel, clear err_cnt, fail_vec, pass, and sel_err, and set vector index 0.
- If the latched gate_sel is legal: next state is SETTLE, with a_out,b_out = 0,0 and the settle counter loaded.
- If the latched gate_sel is 6 or 7: next state is DONE, with sel_err=1 and pass=0.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then transition to SAMPLE, holding a_out/b_out stable.
REQ-018 In SAMPLE, the block SHALL compare y_in with the truth-table value of the latched gate for the current {a_out,b_out}.
- On mismatch: increment err_cnt and set fail_vec[index].
- A y_in of X or Z counts as a mismatch.
REQ-019 After SAMPLE of index 0..2, the block SHALL increment the index, drive the next vector on the following edge, and re-enter SETTLE.
REQ-020 After SAMPLE of index 3, the block SHALL enter DONE.
REQ-021 DONE SHALL last one cycle and then return to IDLE; the DONE cycle has the following outputs:
- done=1;
- pass=(err_cnt==0 && !sel_err);
- a_out and b_out return to 0.
REQ-022 Latency: done SHALL assert 4*(SETTLE_CYCLES+1)+1 cycles after the edge that accepted start (13 for the default); for an illegal gate_sel, 1 cycle.
REQ-023 start asserted while busy SHALL be ignored, with no restart and no queuing.
REQ-024 start held high continuously SHALL begin a new run on the IDLE cycle following DONE.
REQ-025 err_cnt SHALL saturate at 4 and cannot wrap.
REQ-026 Results (pass, err_cnt, fail_vec, sel_err) SHALL remain stable from DONE until the next accepted start.
REQ-027 All outputs SHALL be driven from registers; there is no combinational path from y_in or start to any output.

Reset
REQ-028 With rst=1 at a rising edge, the next state SHALL be IDLE and every output SHALL be 0:
- a_out, b_out, busy, done, pass;
- err_cnt, fail_vec, sel_err.
REQ-029 rst SHALL take priority over start and over any in-progress run, including mid-SETTLE and mid-SAMPLE; a run aborted by reset produces no done pulse.
REQ-030 The first start SHALL be accepted on the first rising edge at which rst=0 and start=1.

Verification
REQ-031 Correct NOR gate wired as the gate under test, gate_sel=0, SETTLE_CYCLES=2 -> a_out,b_out sequence 00,01,10,11; done at cycle 13 after start; pass=1, err_cnt=0, fail_vec=0000.
REQ-032 y_in tied to 0, gate_sel=0 -> fail_vec=0001, err_cnt=1, pass=0.
REQ-033 NOR gate under test, gate_sel=4 (XOR) -> fail_vec=0111, err_cnt=3, pass=0.
REQ-034 gate_sel=7 with start -> done one cycle later, sel_err=1, pass=0, busy=1 for that single cycle, a_out/b_out remain 0.
REQ-035 rst=1 asserted during SETTLE of vector 2 -> all outputs 0 on the next edge, no done pulse; a following start runs the full sequence from vector 0.
REQ-036 start pulsed during a run at cycle 5 -> ignored; exactly one done, at cycle 13.

Source files
------------

// File: rtl/gate_exerciser.sv
// Exercises an external 2-input gate through all four input vectors and
// checks its output against the truth table of the selected gate type.
module gate_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec,
    output logic       sel_err
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ERR_MAX = 4;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_d, b_d, busy_d, done_d, pass_d, sel_err_d;
    logic [2:0]         err_d;
    logic [3:0]         fail_d;
    logic               mismatch;

    // Reference truth table; illegal selections never reach SAMPLE.
    function automatic logic gate_eval(input logic [2:0] sel, input logic a, input logic b);
        case (sel)
            3'd0:    gate_eval = ~(a | b);
            3'd1:    gate_eval = a | b;
            3'd2:    gate_eval = a & b;
            3'd3:    gate_eval = ~(a & b);
            3'd4:    gate_eval = a ^ b;
            3'd5:    gate_eval = ~(a ^ b);
            default: gate_eval = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 4'd0;
            sel_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            a_out    <= a_d;
            b_out    <= b_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            err_cnt  <= err_d;
            fail_vec <= fail_d;
            sel_err  <= sel_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        a_d       = a_out;
        b_d       = b_out;
        busy_d    = busy;
        done_d    = 1'b0;
        pass_d    = pass;
        err_d     = err_cnt;
        fail_d    = fail_vec;
        sel_err_d = sel_err;
        // Case inequality so an X/Z from the gate under test counts as a miss.
        mismatch  = (y_in !== gate_eval(sel_q, a_out, b_out));

        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d     = gate_sel;
                    idx_d     = 2'd0;
                    err_d     = 3'd0;
                    fail_d    = 4'd0;
                    pass_d    = 1'b0;
                    sel_err_d = 1'b0;
                    a_d       = 1'b0;
                    b_d       = 1'b0;
                    busy_d    = 1'b1;
                    if (gate_sel >= 3'd6) begin
                        sel_err_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_d[idx_q] = 1'b1;
                    if (err_cnt < 3'(ERR_MAX)) begin
                        err_d = err_cnt + 3'd1;
                    end
                end
                if (idx_q == 2'd3) begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 3'd0) && !sel_err;
                    state_d = DONE;
                end else begin
                    idx_d        = idx_q + 2'd1;
                    {a_d, b_d}   = 2'(idx_q + 2'd1);
                    cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
                    state_d      = SETTLE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: a behavioural gate model drives y_in
// and each run's latency, vectors and results are checked against constants.
module tb_gate_exerciser;

    localparam int unsigned S = 2;
    localparam int MODE_TIE0 = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic       y_in;
    logic       a_out, b_out, busy, done, pass, sel_err;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;
    int         mode = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    gate_exerciser #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .y_in(y_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_vec(fail_vec), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Gate under test model, same encoding as gate_sel plus a stuck-at-0 mode.
    always_comb begin
        case (mode)
            0:       y_in = ~(a_out | b_out);
            1:       y_in = a_out | b_out;
            2:       y_in = a_out & b_out;
            3:       y_in = ~(a_out & b_out);
            4:       y_in = a_out ^ b_out;
            5:       y_in = ~(a_out ^ b_out);
            default: y_in = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".outs"}, {a_out, b_out, busy, done, pass, err_cnt, fail_vec, sel_err}, 32'd0);
    endtask

    // One run; latency counts the accept cycle as cycle 1.
    task automatic run(input string tag, input int m, input logic [2:0] sel, input int pulse_k,
                       input int exp_lat, input logic [3:0] exp_fail, input logic [2:0] exp_err,
                       input logic exp_pass, input logic exp_sel);
        int lat = 0;
        int ndone = 0;
        mode = m;
        @(negedge clk);
        gate_sel = sel;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, ".busy0"}, busy, 1);
            if (k == pulse_k) start = 1'b1;
            if (k == pulse_k + 1) start = 1'b0;
            if (exp_lat > 1 && k < 4 * (S + 1) && (k % (S + 1)) == 0)
                check($sformatf("%s.vec%0d", tag, k / (S + 1)), {a_out, b_out}, k / (S + 1));
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = k + 1;
                    check({tag, ".pass_at_done"}, pass, exp_pass);
                    check({tag, ".ab_at_done"}, {a_out, b_out}, 0);
                    check({tag, ".busy_at_done"}, busy, 1);
                end
            end
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".ndone"}, ndone, 1);
        check({tag, ".fail_vec"}, fail_vec, exp_fail);
        check({tag, ".err_cnt"}, err_cnt, exp_err);
        check({tag, ".pass"}, pass, exp_pass);
        check({tag, ".sel_err"}, sel_err, exp_sel);
        check({tag, ".busy_end"}, busy, 0);
    endtask

    initial begin
        int ndone;
        int waited;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        //   tag        model      sel  pulse lat fail     err   pass  sel_err
        run("nor_ok",   0,         3'd0, -1, 13, 4'b0000, 3'd0, 1'b1, 1'b0);
        run("tie0",     MODE_TIE0, 3'd0, -1, 13, 4'b0001, 3'd1, 1'b0, 1'b0);
        run("nor_xor",  0,         3'd4, -1, 13, 4'b0111, 3'd3, 1'b0, 1'b0);
        run("or_and",   1,         3'd2, -1, 13, 4'b0110, 3'd2, 1'b0, 1'b0);
        run("and_nand", 2,         3'd3, -1, 13, 4'b1111, 3'd4, 1'b0, 1'b0);
        run("xor_xnor", 4,         3'd5, -1, 13, 4'b1111, 3'd4, 1'b0, 1'b0);
        run("and_ok",   2,         3'd2, -1, 13, 4'b0000, 3'd0, 1'b1, 1'b0);
        run("xnor_ok",  5,         3'd5, -1, 13, 4'b0000, 3'd0, 1'b1, 1'b0);
        run("sel7",     0,         3'd7, -1,  1, 4'b0000, 3'd0, 1'b0, 1'b1);
        run("sel6",     0,         3'd6, -1,  1, 4'b0000, 3'd0, 1'b0, 1'b1);
        run("pulse5",   0,         3'd0,  4, 13, 4'b0000, 3'd0, 1'b1, 1'b0);

        // Reset during SETTLE of vector 2, then a clean rerun.
        mode = 0;
        @(negedge clk);
        gate_sel = 3'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2 * (S + 1) + 1) @(negedge clk);
        check("abort.vec2", {a_out, b_out}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("abort");
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort.no_done", ndone, 0);
        run("after_abort", 0, 3'd0, -1, 13, 4'b0000, 3'd0, 1'b1, 1'b0);

        // start held high: a new run begins on the IDLE cycle after DONE.
        mode = 0;
        @(negedge clk);
        gate_sel = 3'd0;
        start = 1'b1;
        waited = 0;
        while (!done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("hold.first_done", done, 1);
        @(negedge clk);
        check("hold.idle_gap", busy, 0);
        @(negedge clk);
        check("hold.restart", busy, 1);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("hold.second_done", done, 1);
        check("hold.pass", pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
